// File: rtl/conv_pool.sv
// ReLU followed by 2x2 stride-2 max-pool over a raster stream of OW x OH samples.
// Horizontal pairs are reduced first; even-row results wait in a half-width line buffer.
module conv_pool #(
  parameter int OW = 26,
  parameter int OH = 26,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  output logic [9:0]    pool_count
);

  localparam int CW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int LBN = (OW / 2 > 0) ? OW / 2 : 1;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  localparam logic [CW-1:0] COL_MAX  = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(2 * (OW / 2) - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * (OH / 2) - 1);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [DW-1:0]  pair;
  logic [DW-1:0]  line_buf [LBN];

  logic           beat;
  logic           col_end;
  logic           row_end;
  logic [DW-1:0]  relu_data;
  logic [DW-1:0]  hmax;
  logic [DW-1:0]  lb_rd;
  logic [DW-1:0]  vmax;
  logic [LBW-1:0] lb_idx;
  logic           pair_we;
  logic           lb_we;
  logic           emit;

  // A trailing odd column or row never reaches pair_we/lb_we/emit because its index is even.
  always_comb begin
    beat      = in_valid & ~clear;
    col_end   = (col == COL_MAX);
    row_end   = (row == ROW_MAX);
    relu_data = in_data[DW-1] ? '0 : in_data;
    hmax      = (relu_data > pair) ? relu_data : pair;
    lb_idx    = LBW'(col >> 1);
    lb_rd     = line_buf[lb_idx];
    vmax      = (lb_rd > hmax) ? lb_rd : hmax;
    pair_we   = beat & ~col[0] & ~col_end;
    lb_we     = beat & col[0] & ~row[0] & ~row_end;
    emit      = beat & col[0] & row[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      col <= col_end ? '0 : col + 1'b1;
      if (col_end) begin
        row <= row_end ? '0 : row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair <= '0;
    end else if (clear) begin
      pair <= '0;
    end else if (pair_we) begin
      pair <= relu_data;
    end
  end

  // Every entry is rewritten on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[lb_idx] <= hmax;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      pool_count <= '0;
    end else begin
      out_valid <= emit;
      out_last  <= emit & (row == ROW_LAST) & (col == COL_LAST);
      if (emit) begin
        out_data <= vmax;
      end
      if (clear) begin
        pool_count <= '0;
      end else if (emit) begin
        pool_count <= pool_count + 10'd1;
      end else if (out_valid & out_last) begin
        pool_count <= '0;
      end
    end
  end

endmodule
